mem_port_arbiter: RTL

Shares the core's single word-wide data-memory port between instruction fetch (IF) and the load/store unit (LS). Accepts one request at a time through valid/ready handshakes, arbitrates with LS priority plus IF starvation protection, and performs RV32 byte-lane steering (byte enables, store replication, load extraction with sign/zero extension). It checks alignment and func3 legality, then issues a req/gnt transaction to memory and returns a one-cycle response pulse to the owning requester. Sits between the fetch/MA stages and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 22 ++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: shared word-wide data-memory bus.
// req/gnt request phase, rvalid completes reads and writes.
interface mem_port_arbiter_if;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: IF/LS sharing of the data-memory port,
// LS priority with IF starvation guard, RV32 lane steering.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_addr,
    input  logic        ls_we,
    input  logic [2:0]  ls_func3,
    input  logic [31:0] ls_wdata,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        ls_rsp_err,
    mem_port_arbiter_if.master mem
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  starve_cnt;
    logic [31:0] addr_q, wdata_q;
    logic        we_q, own_ls;
    logic [2:0]  f3_q;

    logic        ls_win, if_win, acc_ls, acc_if, acc;
    logic [31:0] addr_d;
    logic        we_d, ill_d, mis_d, bad_d;
    logic [2:0]  f3_d;
    logic [1:0]  off;
    logic        is_b, is_h, issue;
    logic [3:0]  be;
    logic [31:0] wd, lane, ld;

    always_comb begin
        ls_win = ls_req_valid &&
                 (!if_req_valid || starve_cnt != 4'(STARVE_LIMIT));
        if_win = if_req_valid && !ls_win;
        acc_ls = (state == IDLE) && ls_win;
        acc_if = (state == IDLE) && if_win;
        acc    = acc_ls || acc_if;
        ls_req_ready = acc_ls;
        if_req_ready = acc_if;
    end

    // IF is always a plain word load
    always_comb begin
        addr_d = acc_ls ? ls_addr : if_addr;
        we_d   = acc_ls && ls_we;
        f3_d   = acc_ls ? ls_func3 : 3'b010;
        ill_d  = (f3_d[1:0] == 2'b11) || (f3_d == 3'b110) ||
                 (f3_d[2] && we_d);
        mis_d  = (f3_d[1:0] == 2'b01 && addr_d[0]) ||
                 (f3_d[1:0] == 2'b10 && addr_d[1:0] != 2'b00);
        bad_d  = ill_d || mis_d;
    end

    always_comb begin
        off  = addr_q[1:0];
        is_b = f3_q[1:0] == 2'b00;
        is_h = f3_q[1:0] == 2'b01;
        be   = 4'b1111;
        wd   = wdata_q;
        unique case (1'b1)
            is_b: begin
                be = 4'b0001 << off;
                wd = {4{wdata_q[7:0]}};
            end
            is_h: begin
                be = 4'b0011 << off;
                wd = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        issue         = state == ISSUE;
        mem.mem_req   = issue;
        mem.mem_we    = issue && we_q;
        mem.mem_addr  = issue ? {addr_q[31:2], 2'b00} : '0;
        mem.mem_be    = issue ? be : '0;
        mem.mem_wdata = issue ? wd : '0;
    end

    always_comb begin
        lane = mem.mem_rdata >> {off, 3'b000};
        ld   = lane;
        unique case (f3_q)
            3'b000:  ld = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld = {24'h0, lane[7:0]};
            3'b101:  ld = {16'h0, lane[15:0]};
            default: ld = lane;
        endcase
        if (we_q) ld = '0;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (acc) state_nx = bad_d ? RESP : ISSUE;
            ISSUE: if (mem.mem_gnt) state_nx = WAIT;
            WAIT:  if (mem.mem_rvalid) state_nx = RESP;
            RESP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign if_rsp_valid = (state == RESP) && !own_ls;
    assign ls_rsp_valid = (state == RESP) && own_ls;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            own_ls      <= 1'b0;
            if_rsp_data <= '0;
            if_rsp_err  <= 1'b0;
            ls_rsp_data <= '0;
            ls_rsp_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (acc) begin
                addr_q  <= addr_d;
                we_q    <= we_d;
                f3_q    <= f3_d;
                wdata_q <= acc_ls ? ls_wdata : '0;
                own_ls  <= acc_ls;
            end
            if (acc_if)
                starve_cnt <= '0;
            else if (acc_ls && if_req_valid &&
                     starve_cnt != 4'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 4'd1;
            // response fields update only when a pulse is due
            if (acc && bad_d) begin
                if (acc_ls) begin
                    ls_rsp_data <= '0;
                    ls_rsp_err  <= 1'b1;
                end else begin
                    if_rsp_data <= '0;
                    if_rsp_err  <= 1'b1;
                end
            end
            if (state == WAIT && mem.mem_rvalid) begin
                if (own_ls) begin
                    ls_rsp_data <= ld;
                    ls_rsp_err  <= 1'b0;
                end else begin
                    if_rsp_data <= ld;
                    if_rsp_err  <= 1'b0;
                end
            end
        end
    end

endmodule
